// File: rtl/store_buffer_fwd.sv
// Store buffer with commit pointer and per-byte, youngest-wins store-to-load forwarding.
// Committed entries drain in order; flush drops only the uncommitted tail of the queue.
module store_buffer_fwd #(
  parameter int SB_DEPTH = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LD_PORTS = 2,
  localparam int NB  = DATA_W / 8,
  localparam int OFS = $clog2(NB),
  localparam int PW  = $clog2(SB_DEPTH),
  localparam int CW  = PW + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush_i,
  input  logic                             enq_valid_i,
  output logic                             enq_ready_o,
  input  logic [ADDR_W-1:0]                enq_addr_i,
  input  logic [DATA_W-1:0]                enq_data_i,
  input  logic [NB-1:0]                    enq_strb_i,
  input  logic                             enq_uncached_i,
  input  logic                             commit_i,
  output logic                             deq_valid_o,
  input  logic                             deq_ready_i,
  output logic [ADDR_W-1:0]                deq_addr_o,
  output logic [DATA_W-1:0]                deq_data_o,
  output logic [NB-1:0]                    deq_strb_o,
  output logic                             deq_uncached_o,
  input  logic [LD_PORTS-1:0][ADDR_W-1:0]  ld_addr_i,
  output logic [LD_PORTS-1:0][DATA_W-1:0]  fwd_data_o,
  output logic [LD_PORTS-1:0][NB-1:0]      fwd_mask_o,
  output logic [CW-1:0]                    count_o,
  output logic [CW-1:0]                    uncmt_count_o,
  output logic                             full_o
);

  logic [PW-1:0] head, cptr, tail;
  logic [PW-1:0] head_nxt, cptr_nxt, tail_nxt;
  logic [CW-1:0] count, ucount;
  logic [CW-1:0] count_nxt, ucount_nxt, drop;

  logic [ADDR_W-1:0] addr_q [SB_DEPTH];
  logic [DATA_W-1:0] data_q [SB_DEPTH];
  logic [NB-1:0]     strb_q [SB_DEPTH];
  logic              unc_q  [SB_DEPTH];

  logic enq_fire, cmt_fire, deq_fire;
  logic unused_ld;

  assign full_o        = (count == CW'(SB_DEPTH));
  assign count_o       = count;
  assign uncmt_count_o = ucount;
  assign enq_ready_o   = !full_o && !flush_i;
  assign deq_valid_o   = ((count - ucount) != '0);

  assign enq_fire = enq_valid_i && enq_ready_o;
  assign cmt_fire = commit_i && (ucount != '0);
  assign deq_fire = deq_valid_o && deq_ready_i;

  assign unused_ld = ^ld_addr_i;

  // Head is always committed whenever deq_valid_o is high; payload is masked otherwise.
  assign deq_addr_o     = deq_valid_o ? addr_q[head] : '0;
  assign deq_data_o     = deq_valid_o ? data_q[head] : '0;
  assign deq_strb_o     = deq_valid_o ? strb_q[head] : '0;
  assign deq_uncached_o = deq_valid_o ? unc_q[head]  : 1'b0;

  always_comb begin
    head_nxt   = head + PW'(deq_fire);
    cptr_nxt   = cptr + PW'(cmt_fire);
    tail_nxt   = tail + PW'(enq_fire);
    drop       = '0;
    ucount_nxt = ucount + CW'(enq_fire) - CW'(cmt_fire);
    if (flush_i) begin
      // Entries still uncommitted after this cycle's commit are discarded.
      drop       = ucount - CW'(cmt_fire);
      tail_nxt   = cptr_nxt;
      ucount_nxt = '0;
    end
    count_nxt = count + CW'(enq_fire) - CW'(deq_fire) - drop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head   <= '0;
      cptr   <= '0;
      tail   <= '0;
      count  <= '0;
      ucount <= '0;
    end else begin
      head   <= head_nxt;
      cptr   <= cptr_nxt;
      tail   <= tail_nxt;
      count  <= count_nxt;
      ucount <= ucount_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      addr_q[tail] <= enq_addr_i;
      data_q[tail] <= enq_data_i;
      strb_q[tail] <= enq_strb_i;
      unc_q[tail]  <= enq_uncached_i;
    end
  end

  // Entries viewed in age order from head, so later matches are younger.
  logic [PW-1:0] age_idx [SB_DEPTH];
  logic          age_occ [SB_DEPTH];

  for (genvar k = 0; k < SB_DEPTH; k++) begin : g_age
    assign age_idx[k] = head + PW'(k);
    assign age_occ[k] = (CW'(k) < count);
  end

  always_comb begin
    fwd_data_o = '0;
    fwd_mask_o = '0;
    for (int p = 0; p < LD_PORTS; p++) begin
      for (int k = 0; k < SB_DEPTH; k++) begin
        if (age_occ[k] &&
            addr_q[age_idx[k]][ADDR_W-1:OFS] == ld_addr_i[p][ADDR_W-1:OFS]) begin
          for (int j = 0; j < NB; j++) begin
            if (strb_q[age_idx[k]][j]) begin
              fwd_mask_o[p][j]       = 1'b1;
              fwd_data_o[p][j*8 +: 8] = data_q[age_idx[k]][j*8 +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Directed bench for store_buffer_fwd: reset, fill, forward merge, flush, commit/reset,
// and a wrap-around stream checked against an in-order scoreboard.
module tb_store_buffer_fwd;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_i, enq_valid_i, enq_ready_o, enq_uncached_i, commit_i;
  logic deq_valid_o, deq_ready_i, deq_uncached_o, full_o;
  logic [AW-1:0] enq_addr_i, deq_addr_o;
  logic [DW-1:0] enq_data_i, deq_data_o;
  logic [NB-1:0] enq_strb_i, deq_strb_o;
  logic [1:0][AW-1:0] ld_addr_i;
  logic [1:0][DW-1:0] fwd_data_o;
  logic [1:0][NB-1:0] fwd_mask_o;
  logic [3:0] count_o, uncmt_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_buffer_fwd dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_addr_i(enq_addr_i), .enq_data_i(enq_data_i), .enq_strb_i(enq_strb_i),
    .enq_uncached_i(enq_uncached_i), .commit_i(commit_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
    .deq_addr_o(deq_addr_o), .deq_data_o(deq_data_o), .deq_strb_o(deq_strb_o),
    .deq_uncached_o(deq_uncached_o), .ld_addr_i(ld_addr_i),
    .fwd_data_o(fwd_data_o), .fwd_mask_o(fwd_mask_o),
    .count_o(count_o), .uncmt_count_o(uncmt_count_o), .full_o(full_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; enq_valid_i = 0; commit_i = 0; deq_ready_i = 0;
    enq_addr_i = '0; enq_data_i = '0; enq_strb_i = '0; enq_uncached_i = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic enq(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    enq_valid_i = 1; enq_addr_i = a; enq_data_i = d; enq_strb_i = s;
    step();
    enq_valid_i = 0;
  endtask

  logic [DW-1:0] sb_q [$];
  int accepted, drained, nxt;

  initial begin
    ld_addr_i = '0;
    do_reset();

    chk("rst_count", count_o, 0);
    chk("rst_ucount", uncmt_count_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_deq_valid", deq_valid_o, 0);
    chk("rst_enq_ready", enq_ready_o, 1);
    chk("rst_fwd_mask", fwd_mask_o, 0);

    // Fill to capacity without committing.
    for (int i = 0; i < 8; i++) enq(32'h200 + 32'(4 * i), 32'(i), 4'hF);
    chk("fill_count", count_o, 8);
    chk("fill_full", full_o, 1);
    chk("fill_enq_ready", enq_ready_o, 0);
    chk("fill_deq_valid", deq_valid_o, 0);
    chk("fill_ucount", uncmt_count_o, 8);
    enq(32'h300, 32'hDEAD, 4'hF);
    chk("fill_9th_count", count_o, 8);
    ld_addr_i[0] = 32'h21C;
    #1;
    chk("fill_fwd_last", fwd_data_o[0], 7);
    do_reset();

    // Forward merge of two stores to the same word.
    enq(32'h100, 32'h11223344, 4'b1111);
    enq_valid_i = 1; enq_addr_i = 32'h100; enq_data_i = 32'hAABBCCDD; enq_strb_i = 4'b0010;
    ld_addr_i[0] = 32'h102; ld_addr_i[1] = 32'h104;
    #1;
    chk("merge_pre_edge", fwd_data_o[0], 32'h11223344);
    step();
    enq_valid_i = 0;
    #1;
    chk("merge_data0", fwd_data_o[0], 32'h1122CC44);
    chk("merge_mask0", fwd_mask_o[0], 4'hF);
    chk("merge_mask1", fwd_mask_o[1], 4'h0);
    chk("merge_data1", fwd_data_o[1], 0);
    ld_addr_i[1] = 32'h100;
    #1;
    chk("merge_port1_same", fwd_data_o[1], 32'h1122CC44);
    do_reset();

    // Flush with a same-cycle commit keeps the two committed entries.
    enq(32'h300, 32'hA0, 4'hF);
    enq(32'h304, 32'hA1, 4'hF);
    enq(32'h308, 32'hA2, 4'hF);
    commit_i = 1;
    step();
    flush_i = 1; commit_i = 1; enq_valid_i = 1; enq_addr_i = 32'h400; enq_data_i = 32'hEE;
    enq_strb_i = 4'hF;
    #1;
    chk("flush_enq_blocked", enq_ready_o, 0);
    step();
    idle();
    #1;
    chk("flush_count", count_o, 2);
    chk("flush_ucount", uncmt_count_o, 0);
    chk("flush_deq_valid", deq_valid_o, 1);
    ld_addr_i[0] = 32'h308; ld_addr_i[1] = 32'h400;
    #1;
    chk("flush_dropped_fwd", fwd_mask_o[0], 0);
    chk("flush_blocked_fwd", fwd_mask_o[1], 0);
    chk("flush_deq0_addr", deq_addr_o, 32'h300);
    chk("flush_deq0_data", deq_data_o, 32'hA0);
    ld_addr_i[0] = 32'h300;
    deq_ready_i = 1;
    #1;
    chk("deq_cycle_fwd", fwd_mask_o[0], 4'hF);
    step();
    chk("flush_deq1_addr", deq_addr_o, 32'h304);
    chk("flush_deq1_data", deq_data_o, 32'hA1);
    step();
    deq_ready_i = 0;
    chk("flush_drained", deq_valid_o, 0);
    chk("flush_empty", count_o, 0);

    // Commit with nothing uncommitted is ignored.
    enq(32'h500, 32'h1, 4'hF);
    commit_i = 1; step();
    commit_i = 1; step();
    commit_i = 0;
    chk("cmt_empty_ucount", uncmt_count_o, 0);
    enq(32'h504, 32'h2, 4'hF);
    chk("cmt_empty_ucount2", uncmt_count_o, 1);
    chk("cmt_empty_count", count_o, 2);
    do_reset();

    // Reset with four committed entries pending discards them.
    for (int i = 0; i < 4; i++) enq(32'h600 + 32'(4 * i), 32'(i), 4'hF);
    commit_i = 1;
    repeat (4) step();
    commit_i = 0;
    chk("pend_count", count_o, 4);
    chk("pend_deq_valid", deq_valid_o, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("rstpend_count", count_o, 0);
    chk("rstpend_deq_valid", deq_valid_o, 0);
    chk("rstpend_ucount", uncmt_count_o, 0);

    // Wrap: continuous enqueue/commit with toggling drain readiness.
    accepted = 0; drained = 0; nxt = 0;
    for (int c = 0; c < 20; c++) begin
      enq_valid_i = 1; enq_addr_i = 32'h800 + 32'(4 * nxt); enq_data_i = 32'h5000 + 32'(nxt);
      enq_strb_i = 4'hF; commit_i = 1; deq_ready_i = c[0];
      #1;
      if (enq_ready_o) begin
        sb_q.push_back(enq_data_i);
        accepted++;
        nxt++;
      end
      if (deq_valid_o && deq_ready_i) begin
        chk("wrap_order", deq_data_o, sb_q.pop_front());
        drained++;
      end
      step();
    end
    enq_valid_i = 0;
    for (int c = 0; c < 40 && count_o != 0; c++) begin
      commit_i = 1; deq_ready_i = 1;
      #1;
      if (deq_valid_o) begin
        chk("wrap_order", deq_data_o, sb_q.pop_front());
        drained++;
      end
      step();
    end
    idle();
    chk("wrap_empty", count_o, 0);
    chk("wrap_no_loss", 64'(drained), 64'(accepted));
    chk("wrap_past_depth", 64'(accepted > 8), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
